led_bank_scheduler: RTL and testbench
=====================================

# led_bank_scheduler

Shares the Go Board's four-LED bank between the four push buttons. Each raw button is synchronized and debounced. Each debounced press becomes a queued request, and a round-robin scheduler grants the LED bank to one requester at a time. The owner's LED blinks for a fixed hold window, followed by a dark gap. The block sits between the board button pins and LED pins, in place of the direct button-to-LED wiring.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles needed to accept a button level (10 ms at 25 MHz).
- `HOLD_CYCLES`, default 12500000: length of an ownership window, in cycles.
- `BLINK_HALF`, default 2500000: cycles per LED on/off phase inside the window.
- `GAP_CYCLES`, default 250000: dark cycles after each window.
- Parameter legality: all parameters ≥1, and `BLINK_HALF` ≤ `HOLD_CYCLES`.
- `clk` input, 1 bit: single system clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `btn` input, 4 bits: raw button pins, active-high, asynchronous to `clk`.
- `led` output, 4 bits: LED drive, active-high.
- `busy` output, 1 bit: high while a window or gap is in progress.
- `owner` output, 2 bits: index of the current or most recent grantee.

## Operation
- **Per-button front end:**
  - 2-FF synchronizer feeding a debouncer.
  - The debounced level changes only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing cycle clears the counter.
- **Requests:**
  - A 0→1 edge of the debounced level sets `pend[i]`.
  - Releases are ignored.
  - A press while `pend[i]` is already set is absorbed, so there is no count.
- **FSM states:** IDLE, GRANT, SHOW, GAP.
  - IDLE: `led`=0, `busy`=0. If `pend`≠0, go to GRANT.
  - GRANT: one cycle. Select the first set `pend` bit scanning from `last+1` mod 4 upward. Load `owner` and `last`, clear that `pend` bit, and go to SHOW.
  - SHOW: exactly `HOLD_CYCLES` cycles. `led[owner]` = blink phase, all other LEDs 0. The phase starts at 1 and toggles every `BLINK_HALF` cycles. Then go to GAP.
  - GAP: exactly `GAP_CYCLES` cycles with `led`=0. Then go to IDLE.
- **Round-robin pointer:** `last` resets to 3, so button 0 wins the first tie.
- **Requests during a window:**
  - A press by the current owner during SHOW or GAP re-queues it.
  - A press and a grant clearing the same bit in the same cycle: the set wins, and the request stays pending.
- **`busy` and `owner`:** `busy`=1 in GRANT, SHOW and GAP. `owner` holds its value in IDLE.
- **Counter widths:** every counter is `$clog2(max+1)` bits. Counters saturate or reload and never wrap mid-window.
- **Reset mid-window:** abort the window immediately, clear `pend`, and return to IDLE.

## Timing
- Reset values: `led`=0, `busy`=0, `owner`=0, `pend`=0, `last`=3, debounced levels=0, state IDLE.
- Press latency: 2 sync cycles + `DEBOUNCE_CYCLES` to the debounced edge, then +1 cycle to `pend`, +1 to GRANT, +1 to the first SHOW cycle. `led` and `busy` are registered.
- From a stable raw level to the first lit LED (IDLE case): `DEBOUNCE_CYCLES`+5 cycles, with the LED visible on the following edge.
- Back-to-back service: from the last GAP cycle, IDLE lasts 1 cycle before the next GRANT. Period per grant = 1 + 1 + `HOLD_CYCLES` + `GAP_CYCLES` cycles.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no request.
- Simultaneous presses produce simultaneous `pend` bits, which are served in round-robin order.

## Structure
- **Package `led_sched_pkg`:**
  - `BTN_COUNT`=4.
  - state enum `sched_state_t` {IDLE, GRANT, SHOW, GAP}.
  - owner index type (2 bits).
- **Sub-module `btn_debounce`** (param `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `raw`, `level`, `rise`), instantiated 4×.
- **Top level:** pending register, round-robin pick, FSM, hold/blink/gap counters.

## Test plan
Test parameters: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=8, `BLINK_HALF`=2, `GAP_CYCLES`=2.
- **Single press:** `btn`=0001 held 10 cycles → `led` = 0001,0001,0000,0000,0001,0001,0000,0000, then 2 cycles of 0000 with `busy`=1, then `busy`=0; `owner`=0.
- **Bounce rejection:** `btn[2]` toggling every 3 cycles for 30 cycles → `pend`=0, `busy` never asserted.
- **Simultaneous presses:** `btn`=1010 pressed together → grants `owner`=1 then 3, each window 8 cycles, with GAP + 1 IDLE between.
- **Fairness:** owner 1 re-presses during its SHOW while button 3 is pending → next grant is 3, then 1.
- **Reset mid-window:** `rst_n` pulsed low during SHOW cycle 3 → `led`=0, `busy`=0, `owner`=0 the same cycle; no stale grant after release.
- **Same-cycle set and clear:** button 0's rise coincides with GRANT of button 0 → `pend[0]` remains 1 and button 0 is granted again after GAP.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED bank scheduler: state encoding,
// owner index type and the round-robin pick.
package led_sched_pkg;

  localparam int BTN_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SHOW  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  typedef logic [1:0] owner_t;

  // First set request scanning upward from last+1, wrapping; returns last when none set.
  function automatic owner_t rr_pick(input logic [BTN_COUNT-1:0] req, input owner_t last);
    owner_t idx;
    logic   found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= BTN_COUNT; k++) begin
      idx = last + owner_t'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [BTN_COUNT-1:0] owner_onehot(input owner_t o);
    owner_onehot = '0;
    owner_onehot[o] = 1'b1;
  endfunction

endpackage

// File: rtl/led_bank_scheduler_btn_debounce.sv
// Per-button front end: 2-FF synchronizer followed by a level debouncer
// that emits a one-cycle rise pulse together with each accepted 0->1 change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any agreeing cycle restarts the count, so only an unbroken run flips the level.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_bank_scheduler.sv
// Shares the four-LED bank between four debounced buttons: each press queues a
// request, a round-robin FSM grants one owner a blinking window followed by a dark gap.
module led_bank_scheduler
  import led_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000,
  parameter int BLINK_HALF      = 2500000,
  parameter int GAP_CYCLES      = 250000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_COUNT-1:0] btn,
  output logic [BTN_COUNT-1:0] led,
  output logic                 busy,
  output owner_t               owner,
  output sched_state_t         dbg_state,
  output logic [BTN_COUNT-1:0] dbg_pend,
  output logic [BTN_COUNT-1:0] dbg_level
);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || BLINK_HALF < 1 || GAP_CYCLES < 1
      || BLINK_HALF > HOLD_CYCLES) begin : g_param_check
    $error("led_bank_scheduler: illegal timing parameters");
  end

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  logic [BTN_COUNT-1:0] level;
  logic [BTN_COUNT-1:0] rise;
  logic [BTN_COUNT-1:0] pend;
  logic [BTN_COUNT-1:0] grant_clr;
  sched_state_t         state;
  owner_t               last;
  owner_t               pick;
  logic [HW-1:0]        hold_cnt;
  logic [BW-1:0]        blink_cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 phase;

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  assign pick      = rr_pick(pend, last);
  assign grant_clr = (state == GRANT) ? owner_onehot(pick) : '0;

  // A rise landing on the grant of the same button re-queues it: set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~grant_clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      led       <= '0;
      busy      <= 1'b0;
      owner     <= '0;
      last      <= owner_t'(BTN_COUNT - 1);
      hold_cnt  <= '0;
      blink_cnt <= '0;
      gap_cnt   <= '0;
      phase     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          led  <= '0;
          busy <= 1'b0;
          if (|pend) begin
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          owner     <= pick;
          last      <= pick;
          hold_cnt  <= '0;
          blink_cnt <= '0;
          phase     <= 1'b1;
          led       <= owner_onehot(pick);
          state     <= SHOW;
        end
        SHOW: begin
          if (hold_cnt == HOLD_LAST) begin
            led     <= '0;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              phase     <= ~phase;
              led       <= phase ? '0 : owner_onehot(owner);
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          led <= '0;
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          led   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_pend  = pend;
  assign dbg_level = level;

endmodule

// File: tb/tb_led_bank_scheduler.sv
// Bench for led_bank_scheduler: directed scenarios plus random button traffic,
// all cycles compared against a timeline-based reference model.
module tb_led_bank_scheduler;
  import led_sched_pkg::*;

  localparam int D = 4;
  localparam int H = 8;
  localparam int BH = 2;
  localparam int G = 2;
  localparam int PERIOD = 1 + 1 + H + G;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   btn = 4'b0;
  logic [3:0]   led;
  logic         busy;
  owner_t       owner;
  sched_state_t dbg_state;
  logic [3:0]   dbg_pend;
  logic [3:0]   dbg_level;

  led_bank_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .BLINK_HALF     (BH),
    .GAP_CYCLES     (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .led      (led),
    .busy     (busy),
    .owner    (owner),
    .dbg_state(dbg_state),
    .dbg_pend (dbg_pend),
    .dbg_level(dbg_level)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce: level flips when the last D synchronized samples all disagree with it.
  // Scheduler: a grant at edge ws gives SHOW for offsets 1..H and GAP for H+1..H+G.
  logic [3:0]   hist[$];
  logic [3:0]   m_deb, m_rise, m_pend, m_led;
  logic         m_busy;
  sched_state_t m_state;
  int           m_n, m_ws, m_owner, m_last;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back(4'b0);
    m_deb = '0; m_rise = '0; m_pend = '0; m_led = '0;
    m_busy = 1'b0; m_state = IDLE;
    m_n = 0; m_ws = -1000; m_owner = 0; m_last = 3;
  endtask

  task automatic model_step();
    logic [3:0] od, orise, op, clr;
    int d, pick, idx;
    bit differ_all, found, idle_before;
    m_n++;
    od = m_deb; orise = m_rise; op = m_pend;
    for (int i = 0; i < 4; i++) begin
      differ_all = 1'b1;
      for (int k = 1; k <= D; k++) if (hist[k][i] == od[i]) differ_all = 1'b0;
      m_deb[i] = differ_all ? ~od[i] : od[i];
    end
    m_rise = m_deb & ~od;
    hist.push_front(btn);
    void'(hist.pop_back());
    clr = '0;
    if (m_n - m_ws == 1) begin
      found = 1'b0;
      pick = m_last;
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (!found && op[idx]) begin pick = idx; found = 1'b1; end
      end
      m_owner = pick; m_last = pick; clr[pick] = 1'b1;
    end
    idle_before = (m_n - 1 - m_ws) > H + G;
    m_pend = (op & ~clr) | orise;
    if (idle_before && op != 4'b0) m_ws = m_n;
    d = m_n - m_ws;
    m_busy = (d >= 0) && (d <= H + G);
    m_led = (d >= 1 && d <= H && ((d - 1) / BH) % 2 == 0) ? 4'(1 << m_owner) : 4'b0;
    if (d == 0) m_state = GRANT;
    else if (d >= 1 && d <= H) m_state = SHOW;
    else if (d > H && d <= H + G) m_state = GAP;
    else m_state = IDLE;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_led", 32'(led), 32'(m_led));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_owner", 32'(owner), 32'(m_owner));
      check("cyc_state", 32'(dbg_state), 32'(m_state));
      check("cyc_pend", 32'(dbg_pend), 32'(m_pend));
      check("cyc_level", 32'(dbg_level), 32'(m_deb));
    end
  end

  // ---------------- grant monitor / scoreboard ----------------
  owner_t     gq[$];
  int         gt[$];
  logic [1:0] exp_q[$];
  logic       prev_grant = 1'b0;

  always @(negedge clk) begin
    if (rst_n && prev_grant) begin
      gq.push_back(owner);
      gt.push_back(cyc);
    end
    prev_grant = rst_n && (dbg_state == GRANT);
  end

  task automatic clear_grants();
    gq.delete(); gt.delete(); exp_q.delete();
  endtask

  task automatic wait_grants(input int n);
    int k = 0;
    while (gq.size() < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    check("grant_count", gq.size(), n);
  endtask

  task automatic score_grants(input string tag);
    check({tag, "_n"}, gq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < gq.size(); i++)
      check({tag, "_owner"}, 32'(gq[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || dbg_pend != 4'b0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] exp_led[8];
  logic       busy_seen;
  int         segs;

  initial begin
    exp_led = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_pend", 32'(dbg_pend), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_level", 32'(dbg_level), 32'd0);
    #1 rst_n = 1'b1;

    // Single press: blink pattern, gap, then idle
    repeat (4) @(negedge clk);
    clear_grants();
    btn = 4'b0001;
    wait_grants(1);
    for (int j = 0; j < H; j++) begin
      if (j == 1) btn = 4'b0000;
      check("single_led", 32'(led), 32'(exp_led[j]));
      check("single_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    for (int j = 0; j < G; j++) begin
      check("single_gap_led", 32'(led), 32'd0);
      check("single_gap_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("single_end_busy", 32'(busy), 32'd0);
    check("single_owner", 32'(owner), 32'd0);
    wait_idle();

    // Bounce rejection on button 2
    busy_seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      btn[2] = ~btn[2];
      repeat (3) begin
        @(negedge clk);
        busy_seen = busy_seen | busy;
      end
    end
    btn = 4'b0;
    repeat (12) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check("bounce_busy_seen", 32'(busy_seen), 32'd0);
    check("bounce_pend", 32'(dbg_pend), 32'd0);

    // Simultaneous presses on buttons 1 and 3
    clear_grants();
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    btn = 4'b1010;
    wait_grants(1);
    btn = 4'b0000;
    wait_grants(2);
    score_grants("simul");
    if (gt.size() >= 2) check("simul_period", gt[1] - gt[0], PERIOD);
    wait_idle();

    // Fairness: owner 1 re-presses during its window while 3 waits
    clear_grants();
    exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd1);
    btn = 4'b1010;
    repeat (4) @(negedge clk);
    btn = 4'b0000;
    repeat (5) @(negedge clk);
    btn = 4'b0010;
    repeat (5) @(negedge clk);
    btn = 4'b0000;
    wait_grants(3);
    score_grants("fair");
    wait_idle();

    // Same-cycle set and clear: button 0's second rise lands on its own grant
    clear_grants();
    exp_q.push_back(2'd2); exp_q.push_back(2'd1); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    btn = 4'b0110;
    wait_grants(1);
    btn = 4'b0000;
    repeat (9) @(negedge clk);
    btn = 4'b0001;
    repeat (4) @(negedge clk);
    btn = 4'b0000;
    repeat (4) @(negedge clk);
    btn = 4'b0001;
    repeat (5) @(negedge clk);
    btn = 4'b0000;
    wait_grants(3);
    check("setclr_pend0", 32'(dbg_pend[0]), 32'd1);
    wait_grants(4);
    score_grants("setclr");
    if (gt.size() >= 4) check("setclr_period", gt[3] - gt[2], PERIOD);
    wait_idle();

    // Reset in the middle of a window
    clear_grants();
    btn = 4'b0100;
    repeat (5) @(negedge clk);
    btn = 4'b0000;
    wait_grants(1);
    repeat (2) @(negedge clk);
    #2;
    check("midrst_pre_busy", 32'(busy), 32'd1);
    check("midrst_pre_owner", 32'(owner), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_owner", 32'(owner), 32'd0);
    check("midrst_pend", 32'(dbg_pend), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    #1 rst_n = 1'b1;
    clear_grants();
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check("midrst_no_grant", gq.size(), 0);
    check("midrst_busy_seen", 32'(busy_seen), 32'd0);

    // Random button traffic against the model
    segs = 0;
    repeat (160) begin
      btn = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) @(negedge clk);
      segs++;
    end
    btn = 4'b0000;
    wait_idle();
    check("rand_drain_pend", 32'(dbg_pend), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
